// File: rtl/mem_stage.sv
// Memory-access stage: runs load/store transactions on a req/ack data bus and
// registers results into the MEM/WB boundary, stalling upstream while a request is open.
module mem_stage #(
    parameter int WIDTH = 32,
    parameter int INDEX = 5
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 valid_in,
    input  logic                 mem_read_in,
    input  logic                 mem_write_in,
    input  logic                 reg_write_in,
    input  logic [2:0]           funct3_in,
    input  logic [INDEX-1:0]     rd_in,
    input  logic [WIDTH-1:0]     alu_res_in,
    input  logic [WIDTH-1:0]     rs2_data_in,
    output logic                 stall_out,
    output logic                 dmem_req_out,
    output logic                 dmem_we_out,
    output logic [WIDTH-1:0]     dmem_addr_out,
    output logic [WIDTH/8-1:0]   dmem_be_out,
    output logic [WIDTH-1:0]     dmem_wdata_out,
    input  logic                 dmem_ack_in,
    input  logic [WIDTH-1:0]     dmem_rdata_in,
    output logic                 wb_valid_out,
    output logic                 wb_reg_write_out,
    output logic [INDEX-1:0]     wb_rd_out,
    output logic [WIDTH-1:0]     wb_data_out,
    output logic                 misalign_out
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    logic [0:0]         state_q;

    logic               req_q;
    logic               we_q;
    logic [WIDTH-1:0]   addr_q;
    logic [3:0]         be_q;
    logic [WIDTH-1:0]   wdata_q;
    logic [INDEX-1:0]   rd_q;
    logic [2:0]         funct3_q;
    logic               reg_write_q;

    logic               memop;
    logic               size_b;
    logic               size_h;
    logic               size_w;
    logic               misaligned;
    logic               accept;
    logic               ack_hit;
    logic [3:0]         be_next;
    logic [WIDTH-1:0]   wdata_next;
    logic [7:0]         byte_sel;
    logic [15:0]        half_sel;
    logic [WIDTH-1:0]   load_data;

    // Undefined sizes (011, 110, 111) fall through to word handling.
    always_comb begin
        memop   = valid_in & (mem_read_in | mem_write_in);
        size_b  = (funct3_in[1:0] == 2'b00);
        size_h  = (funct3_in[1:0] == 2'b01);
        size_w  = ~size_b & ~size_h;
        misaligned = (size_h & alu_res_in[0]) | (size_w & (alu_res_in[1:0] != 2'b00));
        accept  = (state_q == IDLE) & memop & ~misaligned;
        ack_hit = (state_q == WAIT) & dmem_ack_in;
        stall_out = (state_q == IDLE) ? accept : ~dmem_ack_in;
    end

    always_comb begin
        be_next    = 4'b1111;
        wdata_next = rs2_data_in;
        if (size_b) begin
            be_next    = 4'b0001 << alu_res_in[1:0];
            wdata_next = {4{rs2_data_in[7:0]}};
        end else if (size_h) begin
            be_next    = 4'b0011 << {alu_res_in[1], 1'b0};
            wdata_next = {2{rs2_data_in[15:0]}};
        end
    end

    // Lane selection uses the latched address so the bus word can arrive any cycle.
    always_comb begin
        byte_sel = dmem_rdata_in[7:0];
        case (addr_q[1:0])
            2'b00:   byte_sel = dmem_rdata_in[7:0];
            2'b01:   byte_sel = dmem_rdata_in[15:8];
            2'b10:   byte_sel = dmem_rdata_in[23:16];
            default: byte_sel = dmem_rdata_in[31:24];
        endcase
        half_sel = addr_q[1] ? dmem_rdata_in[31:16] : dmem_rdata_in[15:0];
        case (funct3_q)
            3'b000:  load_data = {{(WIDTH-8){byte_sel[7]}}, byte_sel};
            3'b100:  load_data = {{(WIDTH-8){1'b0}}, byte_sel};
            3'b001:  load_data = {{(WIDTH-16){half_sel[15]}}, half_sel};
            3'b101:  load_data = {{(WIDTH-16){1'b0}}, half_sel};
            default: load_data = dmem_rdata_in;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= IDLE;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            rd_q        <= '0;
            funct3_q    <= '0;
            reg_write_q <= 1'b0;
        end else if (accept) begin
            state_q     <= WAIT;
            req_q       <= 1'b1;
            we_q        <= mem_write_in;
            addr_q      <= alu_res_in;
            be_q        <= be_next;
            wdata_q     <= wdata_next;
            rd_q        <= rd_in;
            funct3_q    <= funct3_in;
            reg_write_q <= reg_write_in;
        end else if (ack_hit) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wb_valid_out     <= 1'b0;
            wb_reg_write_out <= 1'b0;
            wb_rd_out        <= '0;
            wb_data_out      <= '0;
            misalign_out     <= 1'b0;
        end else if (state_q == IDLE) begin
            if (memop && misaligned) begin
                wb_valid_out     <= 1'b1;
                wb_reg_write_out <= 1'b0;
                wb_rd_out        <= rd_in;
                wb_data_out      <= alu_res_in;
                misalign_out     <= 1'b1;
            end else if (memop) begin
                wb_valid_out     <= 1'b0;
                wb_reg_write_out <= 1'b0;
                misalign_out     <= 1'b0;
            end else begin
                wb_valid_out     <= valid_in;
                wb_reg_write_out <= reg_write_in;
                wb_rd_out        <= rd_in;
                wb_data_out      <= alu_res_in;
                misalign_out     <= 1'b0;
            end
        end else if (dmem_ack_in) begin
            // Stores report their address on write-back but never write rd.
            wb_valid_out     <= 1'b1;
            wb_reg_write_out <= reg_write_q & ~we_q;
            wb_rd_out        <= rd_q;
            wb_data_out      <= we_q ? addr_q : load_data;
            misalign_out     <= 1'b0;
        end else begin
            wb_valid_out     <= 1'b0;
            wb_reg_write_out <= 1'b0;
            misalign_out     <= 1'b0;
        end
    end

    assign dmem_req_out   = req_q;
    assign dmem_we_out    = we_q;
    assign dmem_addr_out  = {addr_q[WIDTH-1:2], 2'b00};
    assign dmem_be_out    = be_q;
    assign dmem_wdata_out = wdata_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: loads, stores, misalignment, stall interplay and reset mid-transaction.
module tb_mem_stage;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        valid_in;
    logic        mem_read_in;
    logic        mem_write_in;
    logic        reg_write_in;
    logic [2:0]  funct3_in;
    logic [4:0]  rd_in;
    logic [31:0] alu_res_in;
    logic [31:0] rs2_data_in;
    logic        stall_out;
    logic        dmem_req_out;
    logic        dmem_we_out;
    logic [31:0] dmem_addr_out;
    logic [3:0]  dmem_be_out;
    logic [31:0] dmem_wdata_out;
    logic        dmem_ack_in;
    logic [31:0] dmem_rdata_in;
    logic        wb_valid_out;
    logic        wb_reg_write_out;
    logic [4:0]  wb_rd_out;
    logic [31:0] wb_data_out;
    logic        misalign_out;

    int total = 0;
    int bad   = 0;

    mem_stage #(.WIDTH(32), .INDEX(5)) dut (
        .clk_in           (clk_in),
        .rst_n_in         (rst_n_in),
        .valid_in         (valid_in),
        .mem_read_in      (mem_read_in),
        .mem_write_in     (mem_write_in),
        .reg_write_in     (reg_write_in),
        .funct3_in        (funct3_in),
        .rd_in            (rd_in),
        .alu_res_in       (alu_res_in),
        .rs2_data_in      (rs2_data_in),
        .stall_out        (stall_out),
        .dmem_req_out     (dmem_req_out),
        .dmem_we_out      (dmem_we_out),
        .dmem_addr_out    (dmem_addr_out),
        .dmem_be_out      (dmem_be_out),
        .dmem_wdata_out   (dmem_wdata_out),
        .dmem_ack_in      (dmem_ack_in),
        .dmem_rdata_in    (dmem_rdata_in),
        .wb_valid_out     (wb_valid_out),
        .wb_reg_write_out (wb_reg_write_out),
        .wb_rd_out        (wb_rd_out),
        .wb_data_out      (wb_data_out),
        .misalign_out     (misalign_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic v, input logic rd_en, input logic wr_en, input logic rw,
                                  input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] alu,
                                  input logic [31:0] rs2);
        valid_in     = v;
        mem_read_in  = rd_en;
        mem_write_in = wr_en;
        reg_write_in = rw;
        funct3_in    = f3;
        rd_in        = rd;
        alu_res_in   = alu;
        rs2_data_in  = rs2;
        #1;
    endtask

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    task automatic apply_idle;
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 5'd0, 32'h0, 32'h0);
    endtask

    initial begin
        rst_n_in      = 1'b0;
        dmem_ack_in   = 1'b0;
        dmem_rdata_in = 32'h0;
        apply_idle();
        #12;
        check_output("rst_req",      {31'b0, dmem_req_out}, 32'h0);
        check_output("rst_we",       {31'b0, dmem_we_out}, 32'h0);
        check_output("rst_addr",     dmem_addr_out, 32'h0);
        check_output("rst_be",       {28'b0, dmem_be_out}, 32'h0);
        check_output("rst_wdata",    dmem_wdata_out, 32'h0);
        check_output("rst_wb_valid", {31'b0, wb_valid_out}, 32'h0);
        check_output("rst_wb_rw",    {31'b0, wb_reg_write_out}, 32'h0);
        check_output("rst_wb_rd",    {27'b0, wb_rd_out}, 32'h0);
        check_output("rst_wb_data",  wb_data_out, 32'h0);
        check_output("rst_misalign", {31'b0, misalign_out}, 32'h0);
        check_output("rst_stall",    {31'b0, stall_out}, 32'h0);
        tick();
        rst_n_in = 1'b1;
        tick();

        // LW 0x100 acked in the first wait cycle, followed by an ALU op held by the stall
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 5'd10, 32'h0000_0100, 32'h0);
        check_output("lw_stall_n", {31'b0, stall_out}, 32'h1);
        check_output("lw_req_n",   {31'b0, dmem_req_out}, 32'h0);
        tick();
        check_output("lw_req",     {31'b0, dmem_req_out}, 32'h1);
        check_output("lw_we",      {31'b0, dmem_we_out}, 32'h0);
        check_output("lw_addr",    dmem_addr_out, 32'h0000_0100);
        check_output("lw_be",      {28'b0, dmem_be_out}, 32'hF);
        check_output("lw_bubble",  {31'b0, wb_valid_out}, 32'h0);
        dmem_ack_in   = 1'b1;
        dmem_rdata_in = 32'hDEAD_BEEF;
        #1;
        check_output("lw_stall_ack", {31'b0, stall_out}, 32'h0);
        tick();
        dmem_ack_in = 1'b0;
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 5'd5, 32'h0000_0042, 32'h0);
        check_output("lw_req_drop", {31'b0, dmem_req_out}, 32'h0);
        check_output("lw_wb_valid", {31'b0, wb_valid_out}, 32'h1);
        check_output("lw_wb_data",  wb_data_out, 32'hDEAD_BEEF);
        check_output("lw_wb_rd",    {27'b0, wb_rd_out}, 32'd10);
        check_output("lw_wb_rw",    {31'b0, wb_reg_write_out}, 32'h1);
        check_output("alu_stall",   {31'b0, stall_out}, 32'h0);
        tick();
        apply_idle();
        check_output("alu_wb_valid", {31'b0, wb_valid_out}, 32'h1);
        check_output("alu_wb_rd",    {27'b0, wb_rd_out}, 32'd5);
        check_output("alu_wb_data",  wb_data_out, 32'h0000_0042);

        // LB then LBU back-to-back at 0x103
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 3'b000, 5'd3, 32'h0000_0103, 32'h0);
        tick();
        check_output("lb_be",   {28'b0, dmem_be_out}, 32'h8);
        check_output("lb_addr", dmem_addr_out, 32'h0000_0100);
        dmem_ack_in   = 1'b1;
        dmem_rdata_in = 32'h8012_3456;
        tick();
        dmem_ack_in = 1'b0;
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 3'b100, 5'd4, 32'h0000_0103, 32'h0);
        check_output("lb_data",     wb_data_out, 32'hFFFF_FF80);
        check_output("b2b_req_gap", {31'b0, dmem_req_out}, 32'h0);
        tick();
        check_output("lbu_req", {31'b0, dmem_req_out}, 32'h1);
        dmem_ack_in = 1'b1;
        tick();
        dmem_ack_in = 1'b0;
        apply_idle();
        check_output("lbu_data", wb_data_out, 32'h0000_0080);
        check_output("lbu_rd",   {27'b0, wb_rd_out}, 32'd4);
        tick();

        // SH 0x202 with three wait cycles before ack
        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 3'b001, 5'd0, 32'h0000_0202, 32'h0000_ABCD);
        check_output("sh_stall_n", {31'b0, stall_out}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_output($sformatf("sh_req_%0d", i),   {31'b0, dmem_req_out}, 32'h1);
            check_output($sformatf("sh_we_%0d", i),    {31'b0, dmem_we_out}, 32'h1);
            check_output($sformatf("sh_be_%0d", i),    {28'b0, dmem_be_out}, 32'hC);
            check_output($sformatf("sh_wdata_%0d", i), dmem_wdata_out, 32'hABCD_ABCD);
            check_output($sformatf("sh_addr_%0d", i),  dmem_addr_out, 32'h0000_0200);
            check_output($sformatf("sh_stall_%0d", i), {31'b0, stall_out}, 32'h1);
            check_output($sformatf("sh_wbv_%0d", i),   {31'b0, wb_valid_out}, 32'h0);
        end
        dmem_ack_in = 1'b1;
        #1;
        check_output("sh_stall_ack", {31'b0, stall_out}, 32'h0);
        tick();
        dmem_ack_in = 1'b0;
        apply_idle();
        check_output("sh_wb_valid", {31'b0, wb_valid_out}, 32'h1);
        check_output("sh_wb_rw",    {31'b0, wb_reg_write_out}, 32'h0);
        check_output("sh_wb_data",  wb_data_out, 32'h0000_0202);
        check_output("sh_req_drop", {31'b0, dmem_req_out}, 32'h0);

        // Misaligned LW at 0x101 never touches the bus
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 5'd7, 32'h0000_0101, 32'h0);
        check_output("mis_stall", {31'b0, stall_out}, 32'h0);
        tick();
        apply_idle();
        check_output("mis_req",      {31'b0, dmem_req_out}, 32'h0);
        check_output("mis_flag",     {31'b0, misalign_out}, 32'h1);
        check_output("mis_wb_valid", {31'b0, wb_valid_out}, 32'h1);
        check_output("mis_wb_rw",    {31'b0, wb_reg_write_out}, 32'h0);
        tick();
        check_output("mis_flag_clr", {31'b0, misalign_out}, 32'h0);

        // Stray ack while idle is ignored
        dmem_ack_in = 1'b1;
        tick();
        dmem_ack_in = 1'b0;
        check_output("stray_ack_req", {31'b0, dmem_req_out}, 32'h0);
        check_output("stray_ack_wbv", {31'b0, wb_valid_out}, 32'h0);

        // Reset asserted while waiting abandons the transaction
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 5'd9, 32'h0000_0300, 32'h0);
        tick();
        check_output("rw_req_before", {31'b0, dmem_req_out}, 32'h1);
        rst_n_in = 1'b0;
        #1;
        check_output("rw_req_rst",  {31'b0, dmem_req_out}, 32'h0);
        check_output("rw_wbv_rst",  {31'b0, wb_valid_out}, 32'h0);
        check_output("rw_addr_rst", dmem_addr_out, 32'h0);
        apply_idle();
        tick();
        rst_n_in = 1'b1;
        tick();
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 5'd11, 32'h0000_0104, 32'h0);
        tick();
        check_output("post_req",  {31'b0, dmem_req_out}, 32'h1);
        check_output("post_addr", dmem_addr_out, 32'h0000_0104);
        dmem_ack_in   = 1'b1;
        dmem_rdata_in = 32'h1234_5678;
        tick();
        dmem_ack_in = 1'b0;
        apply_idle();
        check_output("post_wb_valid", {31'b0, wb_valid_out}, 32'h1);
        check_output("post_wb_data",  wb_data_out, 32'h1234_5678);
        check_output("post_wb_rd",    {27'b0, wb_rd_out}, 32'd11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage RISC-V pipeline, directly downstream of the execute stage. It consumes the EX/MEM-registered ALU result (used as the effective address) and the forwarded rs2 value (store data). It runs load/store transactions on a req/ack data-memory bus through a two-state FSM, stalling the upstream pipeline while a transaction is outstanding. Results are presented to write-back through a registered MEM/WB boundary.

## Interface
- WIDTH, 32, datapath width; only 32 is supported (4 byte lanes)
- INDEX, 5, register-index width
- clk_in  input  1  clock, rising edge
- rst_n_in  input  1  reset; one clock, reset asynchronous and active-low
- valid_in  input  1  EX/MEM slot holds a live instruction
- mem_read_in  input  1  instruction is a load
- mem_write_in  input  1  instruction is a store
- reg_write_in  input  1  instruction writes rd
- funct3_in  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- rd_in  input  INDEX  destination register
- alu_res_in  input  WIDTH  ALU result / effective address
- rs2_data_in  input  WIDTH  forwarded store data
- stall_out  output  1  hold PC, IF/ID, ID/EX, EX/MEM
- dmem_req_out  output  1  bus request, registered
- dmem_we_out  output  1  1 = write
- dmem_addr_out  output  WIDTH  word-aligned address ({addr[31:2],2'b00})
- dmem_be_out  output  WIDTH/8  byte enables
- dmem_wdata_out  output  WIDTH  lane-replicated store data
- dmem_ack_in  input  1  transaction complete; rdata valid this cycle for reads
- dmem_rdata_in  input  WIDTH  read word
- wb_valid_out  output  1  MEM/WB slot valid
- wb_reg_write_out  output  1  write-back enable
- wb_rd_out  output  INDEX  destination register
- wb_data_out  output  WIDTH  load data or ALU result
- misalign_out  output  1  misaligned-access flag, coincident with wb_valid_out

## Operation
- memop = valid_in & (mem_read_in | mem_write_in). misaligned = H/HU with addr[0]=1, or W with addr[1:0]!=0.
- FSM states: IDLE, WAIT.
- IDLE, no memop: the MEM/WB register captures valid_in, reg_write_in, rd_in, and alu_res_in. stall_out=0.
- IDLE, memop and misaligned: no bus request is made. The MEM/WB register captures wb_valid=1, wb_reg_write=0, and misalign=1. stall_out=0. The state stays IDLE.
- IDLE, memop and aligned: stall_out=1. The block latches addr, we, be, wdata, rd, funct3, and reg_write into request registers. It loads a bubble into MEM/WB (wb_valid=0). The state moves to WAIT.
- WAIT: dmem_req_out=1, and all dmem_* outputs are held stable. stall_out = ~dmem_ack_in. MEM/WB loads a bubble each cycle without ack.
- WAIT with dmem_ack_in: MEM/WB captures wb_valid=1 and the latched rd and reg_write. wb_data is the extended load data for a load; for a store, wb_data is the latched address and reg_write=0. The state returns to IDLE, and dmem_req_out drops on that edge.
- Byte enables:
  - B: 4'b0001 << addr[1:0]
  - H: 4'b0011 << {addr[1],1'b0}
  - W: 4'b1111
- Store data: B replicates rs2[7:0] into all 4 lanes, H replicates rs2[15:0] into both halves, W is passed as is.
- Load extraction: select the lane by the latched addr[1:0]. B/H sign-extend; BU/HU zero-extend.
- Undefined funct3 (011, 110, 111) is treated as W.
- dmem_ack_in outside WAIT is ignored.

## Timing
- Reset (asynchronous, rst_n_in=0) forces:
  - state IDLE
  - dmem_req_out, dmem_we_out, wb_valid_out, wb_reg_write_out, and misalign_out to 0
  - dmem_addr_out, dmem_be_out, dmem_wdata_out, wb_rd_out, and wb_data_out to 0
- Reset asserted in WAIT abandons the transaction. The bus slave must tolerate a request dropped before ack.
- Non-memory or misaligned instruction: presented in cycle N, appears on wb_* in cycle N+1. No stall.
- Aligned memory op presented in cycle N:
  - dmem_req_out rises in N+1.
  - Earliest ack is in N+1.
  - The result appears on wb_* in (ack cycle)+1.
  - stall_out is high from N through the cycle before the ack cycle, and low in the ack cycle.
- Minimum memory latency is 2 cycles; each wait cycle without ack adds 1.
- Back-to-back memory ops: the second op enters IDLE in the cycle after the ack, and dmem_req_out is low for at least 1 cycle between them.
- stall_out is combinational from state, valid_in, mem_*_in, alu_res_in, funct3_in, and dmem_ack_in. All other outputs are registered.

## Test plan
- LW: addr 0x100, ack in the first WAIT cycle, rdata 0xDEADBEEF -> dmem_req_out high 1 cycle, stall_out high 1 cycle, and 2 cycles after presentation wb_data=0xDEADBEEF, wb_valid=1.
- LB vs LBU: addr 0x103, rdata 0x80123456 -> LB gives wb_data 0xFFFFFF80; LBU gives 0x00000080.
- SH: addr 0x202, rs2 0x0000ABCD, ack delayed 3 cycles -> be=4'b1100, wdata=0xABCDABCD, dmem_addr=0x200, all held stable across the wait; then wb_reg_write=0.
- Misaligned LW: addr 0x101 -> no dmem_req_out, stall_out=0; next cycle misalign_out=1, wb_valid=1, wb_reg_write=0.
- ALU op rd=5, alu_res 0x42 following an LW -> the ALU op is held by stall until the LW ack, then wb shows the LW result, and the next cycle wb shows rd=5, data 0x42.
- Reset asserted in WAIT -> dmem_req_out=0 and wb_valid_out=0 immediately; after release, a new LW completes normally.
